lsu_mc: RTL
===========

// Module: lsu_mc
// PURPOSE
//  Parametrised load/store unit for the pipelined core, placed in the MEM stage.
//  Decodes each access to one of three regions: data memory, output peripherals or input peripherals.
//  Generates byte-lane masks for sub-word stores and aligns/extends loads by address offset.
//  Flags misaligned accesses and drives the pipeline stall for a data memory with DMEM_LAT-cycle read latency.
// PARAMETERS
//  ADDR_W    16       decoded address bits (i_lsu_addr[ADDR_W-1:0])
//  DMEM_BASE 'h2000   first byte address of data memory
//  DMEM_LAST 'h3FFF   last byte address of data memory
//  OPER_BASE 'h7000   output peripheral first address; OPER_LAST 'h703F
//  IPER_BASE 'h7800   input peripheral first address; IPER_LAST 'h781F
//  DMEM_LAT  2        cycles from dmem read request to valid i_dmem_rdata (>=1)
// PORTS
//  i_clk         in   1         clock
//  i_rst_n       in   1         async active-low reset
//  i_req         in   1         MEM-stage load/store valid
//  i_lsu_wren    in   1         1=store, 0=load
//  i_lsu_op      in   3         000 B, 001 H, 010 W, 100 BU, 101 HU (store uses 000/001/010)
//  i_lsu_addr    in   32        byte address
//  i_st_data     in   32        store data, right-aligned
//  o_ld_data     out  32        aligned, extended load result
//  o_ld_valid    out  1         o_ld_data valid this cycle
//  o_stall       out  1         hold IF..MEM stages
//  o_misalign    out  1         misaligned access this cycle
//  o_dmem_req    out  1         dmem access strobe
//  o_dmem_wren   out  1         dmem write
//  o_dmem_addr   out  ADDR_W-2  word index = (addr-DMEM_BASE)>>2
//  o_dmem_bmask  out  4         byte lanes
//  o_dmem_wdata  out  32        lane-replicated store data
//  i_dmem_rdata  in   32        dmem read word
//  o_per_addr    out  ADDR_W    peripheral byte address (passthrough)
//  o_per_wdata   out  32        lane-replicated store data
//  o_per_bmask   out  4         byte lanes
//  o_oper_wren   out  1         output peripheral write
//  i_oper_rdata  in   32        output peripheral readback word (combinational)
//  i_iper_rdata  in   32        input peripheral word (combinational)
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0. o_stall, o_ld_valid, o_misalign, o_dmem_req, o_dmem_wren and o_oper_wren are 0.
//   o_ld_data and o_dmem_bmask are 0.
//  Reset asserted mid-load aborts the load; no o_ld_valid is produced for it.
//  Lanes: off=addr[1:0].
//   B: bmask=1<<off; wdata={4{st[7:0]}}.
//   H: bmask=0011<<off; wdata={2{st[15:0]}}.
//   W: bmask=1111; wdata=st.
//  Misalign: H/HU/SH with off[0]=1, or W/SW with off!=0.
//   o_misalign=1 for that cycle only; no strobes, no stall; o_ld_valid=1 for loads with o_ld_data=0.
//  Unmapped address: loads return 0 with o_ld_valid=1 the same cycle; stores are dropped; no stall.
//  Load extract: lane=rdata>>(8*off); B/H sign-extend; BU/HU zero-extend; W passes through.
//  FSM IDLE:
//   peripheral load: o_ld_data from i_oper_rdata or i_iper_rdata, o_ld_valid=1, same cycle.
//   peripheral store: o_oper_wren=1 (output region only; input-region stores dropped).
//   dmem store: o_dmem_req=o_dmem_wren=1, single cycle, no stall.
//   dmem load: o_dmem_req=1, o_stall=1; latch op/off; cnt<=1.
//    DMEM_LAT==1 -> RESP, else WAIT.
//  FSM WAIT: o_stall=1, i_req ignored, cnt++. When cnt==DMEM_LAT-1 -> RESP.
//  FSM RESP: o_stall=0, o_ld_valid=1, o_ld_data=extract(i_dmem_rdata, latched op/off) -> IDLE.
//   The i_req still presented in RESP is the completing instruction and is not re-accepted.
//  Stall length: exactly DMEM_LAT cycles per dmem load.
//   Back-to-back dmem loads: the second is accepted the cycle after RESP.
// TESTING
//  SB st=0x000000A5 @0x2002 -> o_dmem_wren=1, bmask=0100, wdata=0xA5A5A5A5, addr=0, o_stall=0.
//  LB @0x2003, DMEM_LAT=2, rdata=0x80FF0000 -> o_stall=1 for 2 cycles, then o_ld_valid=1 with o_ld_data=0xFFFFFF80.
//  LHU @0x2002, rdata=0x80FF0000 -> o_ld_data=0x000080FF; back-to-back LW @0x2004 accepted the cycle after RESP.
//  LW @0x2006 -> o_misalign=1, o_dmem_req=0, o_stall=0, o_ld_data=0; SH @0x7001 -> o_oper_wren=0.
//  LW @0x7804, i_iper_rdata=0x12345678 -> same-cycle o_ld_data=0x12345678; SW @0x5000 -> no write strobes.
//  Assert i_rst_n=0 during WAIT -> o_stall=0 immediately; no o_ld_valid follows; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mc.sv
`default_nettype none
// lsu_mc: MEM-stage load/store unit: region decode, byte lanes, load align/extend, dmem latency stall.
// Revision 1.0 - initial release
module lsu_mc #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] DMEM_BASE = 32'h2000,
  parameter logic [31:0] DMEM_LAST = 32'h3FFF,
  parameter logic [31:0] OPER_BASE = 32'h7000,
  parameter logic [31:0] OPER_LAST = 32'h703F,
  parameter logic [31:0] IPER_BASE = 32'h7800,
  parameter logic [31:0] IPER_LAST = 32'h781F,
  parameter int          DMEM_LAT  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_lsu_op,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_valid,
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_dmem_req,
  output logic              o_dmem_wren,
  output logic [ADDR_W-3:0] o_dmem_addr,
  output logic [3:0]        o_dmem_bmask,
  output logic [31:0]       o_dmem_wdata,
  input  logic [31:0]       i_dmem_rdata,
  output logic [ADDR_W-1:0] o_per_addr,
  output logic [31:0]       o_per_wdata,
  output logic [3:0]        o_per_bmask,
  output logic              o_oper_wren,
  input  logic [31:0]       i_oper_rdata,
  input  logic [31:0]       i_iper_rdata
);

  localparam int CNT_W = $clog2(DMEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_off;

  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] w_rel;
  logic [1:0]        w_off;
  logic              w_in_dmem;
  logic              w_in_oper;
  logic              w_in_iper;
  logic              w_misal;
  logic              w_act;
  logic              w_dload;
  logic [3:0]        w_bmask;
  logic [31:0]       w_wdata;
  logic              w_unused;

  function automatic logic [31:0] f_extract(input logic [31:0] rdata,
                                            input logic [2:0]  op,
                                            input logic [1:0]  off);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (op)
      3'b000:  f_extract = {{24{lane[7]}}, lane[7:0]};
      3'b001:  f_extract = {{16{lane[15]}}, lane[15:0]};
      3'b100:  f_extract = {24'h0, lane[7:0]};
      3'b101:  f_extract = {16'h0, lane[15:0]};
      default: f_extract = lane;
    endcase
  endfunction

  assign w_a   = i_lsu_addr[ADDR_W-1:0];
  assign w_off = i_lsu_addr[1:0];
  assign w_rel = w_a - DMEM_BASE[ADDR_W-1:0];

  assign w_in_dmem = (w_a >= DMEM_BASE[ADDR_W-1:0]) && (w_a <= DMEM_LAST[ADDR_W-1:0]);
  assign w_in_oper = (w_a >= OPER_BASE[ADDR_W-1:0]) && (w_a <= OPER_LAST[ADDR_W-1:0]);
  assign w_in_iper = (w_a >= IPER_BASE[ADDR_W-1:0]) && (w_a <= IPER_LAST[ADDR_W-1:0]);

  // op[1] selects word size; op[0] halfword; op[2] only affects load extension
  assign w_misal = (i_lsu_op[1] && (w_off != 2'b00)) ||
                   (!i_lsu_op[1] && i_lsu_op[0] && w_off[0]);

  // Reset gates acceptance so a held instruction cannot re-raise stall while rst_n is low
  assign w_act   = i_req && i_rst_n && (r_state == S_IDLE);
  assign w_dload = w_act && !w_misal && w_in_dmem && !i_lsu_wren;

  always_comb begin
    w_bmask = 4'b1111;
    w_wdata = i_st_data;
    if (!i_lsu_op[1]) begin
      if (i_lsu_op[0]) begin
        w_bmask = 4'b0011 << w_off;
        w_wdata = {2{i_st_data[15:0]}};
      end else begin
        w_bmask = 4'b0001 << w_off;
        w_wdata = {4{i_st_data[7:0]}};
      end
    end
  end

  assign o_dmem_addr  = w_rel[ADDR_W-1:2];
  assign o_dmem_wdata = w_wdata;
  assign o_per_addr   = w_a;
  assign o_per_wdata  = w_wdata;
  assign o_per_bmask  = w_bmask;

  always_comb begin
    o_ld_valid   = 1'b0;
    o_ld_data    = 32'h0;
    o_stall      = 1'b0;
    o_misalign   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_wren  = 1'b0;
    o_dmem_bmask = 4'b0000;
    o_oper_wren  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_act) begin
          if (w_misal) begin
            o_misalign = 1'b1;
            o_ld_valid = !i_lsu_wren;
          end else if (w_in_dmem) begin
            o_dmem_req   = 1'b1;
            o_dmem_wren  = i_lsu_wren;
            o_dmem_bmask = w_bmask;
            o_stall      = !i_lsu_wren;
          end else if (w_in_oper) begin
            if (i_lsu_wren) begin
              o_oper_wren = 1'b1;
            end else begin
              o_ld_valid = 1'b1;
              o_ld_data  = f_extract(i_oper_rdata, i_lsu_op, w_off);
            end
          end else if (w_in_iper) begin
            if (!i_lsu_wren) begin
              o_ld_valid = 1'b1;
              o_ld_data  = f_extract(i_iper_rdata, i_lsu_op, w_off);
            end
          end else begin
            o_ld_valid = !i_lsu_wren;
          end
        end
      end
      S_WAIT: o_stall = 1'b1;
      S_RESP: begin
        o_ld_valid = 1'b1;
        o_ld_data  = f_extract(i_dmem_rdata, r_op, r_off);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'b000;
      r_off   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dload) begin
            r_op    <= i_lsu_op;
            r_off   <= w_off;
            r_cnt   <= CNT_W'(1);
            r_state <= (DMEM_LAT == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DMEM_LAT - 1)) r_state <= S_RESP;
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_unused = ^{i_lsu_addr, w_rel[1:0]};

endmodule
`default_nettype wire
